// File: rtl/s444_resp_misr_if.sv
// Response/control bundle between the s444 netlist, its BIST controller and the MISR.
// The master side drives START and the responses; the slave side returns status and signature.
interface s444_resp_misr_if #(
  parameter int MISR_WIDTH = 16
);
  logic                  START;
  logic                  G107;
  logic                  G108;
  logic                  G118;
  logic                  G119;
  logic                  G167;
  logic                  G168;
`ifdef S444_MISR_MASK_EN
  logic [5:0]            MASK;
`endif
  logic                  BUSY;
  logic                  DONE;
  logic                  PASS;
  logic [MISR_WIDTH-1:0] SIGNATURE;

  modport master (
    output START, G107, G108, G118, G119, G167, G168,
`ifdef S444_MISR_MASK_EN
    output MASK,
`endif
    input  BUSY, DONE, PASS, SIGNATURE
  );

  modport slave (
    input  START, G107, G108, G118, G119, G167, G168,
`ifdef S444_MISR_MASK_EN
    input  MASK,
`endif
    output BUSY, DONE, PASS, SIGNATURE
  );
endinterface

// File: rtl/s444_resp_misr.sv
// s444 BIST response MISR: skips WARMUP_CYCLES, compacts COMPACT_CYCLES, then holds DONE/PASS; no backpressure.
// DONE is seen WARMUP_CYCLES+COMPACT_CYCLES+1 edges after START; optional S444_MISR_MASK_EN adds a per-bit MASK.
module s444_resp_misr #(
  parameter int                    MISR_WIDTH     = 16,
  parameter logic [MISR_WIDTH-1:0] POLY           = 16'hB400,
  parameter logic [MISR_WIDTH-1:0] SEED           = 16'h0000,
  parameter int                    WARMUP_CYCLES  = 21,
  parameter int                    COMPACT_CYCLES = 1024,
  parameter logic [MISR_WIDTH-1:0] GOLDEN         = 16'h0000
) (
  input  logic               CLOCK,
  input  logic               RESET_N,
  input  logic               VDD,
  input  logic               VSS,
  s444_resp_misr_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_COMPACT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [15:0] WARM_LOAD    = 16'(WARMUP_CYCLES - 1);
  localparam logic [15:0] COMPACT_LOAD = 16'(COMPACT_CYCLES - 1);

  state_t                state, state_n;
  logic [15:0]           cnt, cnt_n;
  logic [MISR_WIDTH-1:0] sig, sig_n;
  logic [5:0]            resp;
  logic [MISR_WIDTH-1:0] resp_ext;
  logic [MISR_WIDTH-1:0] misr_next;
  logic                  unused_pins;

  // Supply pins exist only so the netlist-level port list stays intact.
  assign unused_pins = VDD ^ VSS;

`ifdef S444_MISR_MASK_EN
  assign resp = {bus.G168, bus.G167, bus.G119, bus.G118, bus.G108, bus.G107} & ~bus.MASK;
`else
  assign resp = {bus.G168, bus.G167, bus.G119, bus.G118, bus.G108, bus.G107};
`endif

  assign resp_ext  = {{(MISR_WIDTH-6){1'b0}}, resp};
  assign misr_next = {sig[MISR_WIDTH-2:0], 1'b0}
                   ^ (sig[MISR_WIDTH-1] ? POLY : {MISR_WIDTH{1'b0}})
                   ^ resp_ext;

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state <= ST_IDLE;
      cnt   <= 16'd0;
      sig   <= SEED;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sig   <= sig_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sig_n   = sig;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.START) begin
          sig_n = SEED;
          if (WARMUP_CYCLES > 0) begin
            state_n = ST_WARMUP;
            cnt_n   = WARM_LOAD;
          end else begin
            state_n = ST_COMPACT;
            cnt_n   = COMPACT_LOAD;
          end
        end
      end
      ST_WARMUP: begin
        if (cnt == 16'd0) begin
          state_n = ST_COMPACT;
          cnt_n   = COMPACT_LOAD;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      ST_COMPACT: begin
        // The cycle that sees cnt==0 still folds in its response: exactly COMPACT_CYCLES updates.
        sig_n = misr_next;
        if (cnt == 16'd0) begin
          state_n = ST_DONE;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign bus.BUSY      = (state == ST_WARMUP) || (state == ST_COMPACT);
  assign bus.DONE      = (state == ST_DONE);
  assign bus.PASS      = (state == ST_DONE) && (sig == GOLDEN);
  assign bus.SIGNATURE = sig;

endmodule
